gs_sobel3x3: RTL
================

# gs_sobel3x3

Streaming 3x3 Sobel edge-magnitude stage directly downstream of the RGB-to-grayscale converter. It consumes the 8-bit grayscale pixel stream in raster order and keeps two internal line buffers to form a sliding 3x3 window. For every accepted pixel it emits one saturated 8-bit gradient magnitude |Gx|+|Gy|, which feeds the copter-detection thresholding logic.

## Interface
- WIDTH, 640, pixels per line (≥3)
- HEIGHT, 480, lines per frame (≥3)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- gs  in  8  grayscale pixel, unsigned
- gs_valid  in  1  pixel strobe; `gs` is accepted on every cycle where this is high; may be gappy
- edge  out  8  gradient magnitude, saturated to 255
- edge_valid  out  1  one-cycle strobe per accepted input pixel

## Operation
- Counters `col` (0..WIDTH-1) and `row` (0..HEIGHT-1) track the position of the next accepted pixel.
  - `col` wraps to 0 at WIDTH-1 and increments `row`.
  - `row` wraps to 0 at HEIGHT-1 when `col` wraps.
  - Counters advance only on accepted pixels; frame alignment is established by reset only.
- Line buffers `lb0` and `lb1` are WIDTH x 8 each, indexed by `col`. On accept of pixel p at (row, col):
  - New column vector is {lb1[col], lb0[col], p}, i.e. rows row-2, row-1, row.
  - Then lb1[col] ← lb0[col] and lb0[col] ← p.
- Window P[i][j] (i = row, j = column, 0 = oldest) shifts left by one column per accepted pixel; the new column vector enters at j=2.
  - After the shift, the window center corresponds to image pixel (row-1, col-1).
- Gradients, 11-bit signed:
  - Gx = (P02 + 2·P12 + P22) − (P00 + 2·P10 + P20)
  - Gy = (P20 + 2·P21 + P22) − (P00 + 2·P01 + P02)
  - Magnitude is |Gx| + |Gy|, range 0..2040. Values >255 output 255.
- Border rule: if the accepted pixel has row<2 or col<2, the output is 0. This covers rows 0–1 and columns 0–1, including window columns left over from the previous line.
- Output image is the input image shifted by (+1,+1), with the top two rows and left two columns zeroed. The last row and column centers are never produced.
- Line-buffer contents are not cleared by reset. The border rule masks stale data.

## Timing
- Reset values:
  - `edge` = 0, `edge_valid` = 0.
  - `row` = 0, `col` = 0, window registers = 0, pipeline valid bits = 0.
- Pipeline:
  - Stage 1 (edge T): counter/line-buffer update, window shift, and border flag are registered.
  - Stage 2 (edge T+1): Gx, Gy, and saturated magnitude are registered into `edge`.
  - An input accepted at edge T gives `edge_valid` high for exactly the cycle after edge T+1. Latency is 2 clocks.
- Throughput is 1 pixel/clock. Back-to-back `gs_valid` gives back-to-back `edge_valid`. Input gaps reappear as output gaps 2 cycles later.
- No backpressure; the consumer must always accept.
- `edge` holds its last value while `edge_valid` is low.
- `rst` high on any edge:
  - Clears both pipeline stages; pixels in flight are dropped and `edge_valid` is 0 the next cycle.
  - Returns `row`/`col` to 0; the next accepted pixel is (0,0).
  - `gs_valid` during reset is ignored.
- Simultaneous wrap of `col` and `row` (last pixel of frame): the pixel is still processed and the next pixel is (0,0).

## Test plan
All scenarios use WIDTH=8, HEIGHT=6.
- **Constant image:** constant 100 frame, continuous valid → 48 `edge_valid` pulses, all `edge`=0; first pulse 2 cycles after first accept.
- **Vertical step:** cols 0–3 = 10, cols 4–7 = 50 → `edge`=160 for inputs at cols 4 and 5 with row≥2; all other outputs 0.
- **Horizontal step with saturation:** rows 0–2 = 0, rows 3–5 = 255 → `edge`=255 (raw 1020) for inputs at rows 3–4 with col≥2; all other outputs 0.
- **Gappy input:** vertical-step frame with `gs_valid` toggling 1,0,0,1… → identical `edge` sequence to the continuous case; each pulse 2 cycles after its accept.
- **Reset mid-frame:** assert `rst` for 1 cycle after pixel 20, then send a fresh constant frame → no `edge_valid` in the cycle after reset. Outputs for the first 2 rows and first 2 columns of the new frame are 0 despite stale line buffers. All outputs are 0 for the constant frame.
- **Frame-to-frame wrap:** two consecutive vertical-step frames → the second frame's output sequence matches the first exactly.

Source files
------------

// File: rtl/gs_sobel3x3.sv
// gs_sobel3x3: streaming 3x3 Sobel |Gx|+|Gy| edge magnitude, saturated to 8 bits, 2-cycle latency
module gs_sobel3x3 #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gs,
  input  logic       gs_valid,
  output logic [7:0] edge_mag,
  output logic       edge_valid
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0] lb0 [WIDTH];
  logic [7:0] lb1 [WIDTH];
  logic [7:0] p [3][3];
  logic v1, bord;
  logic [9:0] xr, xl, yb, yt;
  logic signed [11:0] gx, gy, ax, ay;
  logic [11:0] mag;
  // line buffers carry no reset; the border flag masks whatever stale data they hold
  always_ff @(posedge clk)
    if (gs_valid) begin
      lb1[col] <= lb0[col];
      lb0[col] <= gs;
    end
  always_ff @(posedge clk)
    if (rst) begin
      col  <= '0;
      row  <= '0;
      v1   <= 1'b0;
      bord <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          p[i][j] <= '0;
    end else begin
      v1 <= gs_valid;
      if (gs_valid) begin
        col  <= (col == CW'(WIDTH-1)) ? '0 : col + 1'b1;
        if (col == CW'(WIDTH-1))
          row <= (row == RW'(HEIGHT-1)) ? '0 : row + 1'b1;
        bord <= (row < RW'(2)) || (col < CW'(2));
        for (int i = 0; i < 3; i++) begin
          p[i][0] <= p[i][1];
          p[i][1] <= p[i][2];
        end
        p[0][2] <= lb1[col];
        p[1][2] <= lb0[col];
        p[2][2] <= gs;
      end
    end
  always_comb begin
    xr  = {2'b0, p[0][2]} + {1'b0, p[1][2], 1'b0} + {2'b0, p[2][2]};
    xl  = {2'b0, p[0][0]} + {1'b0, p[1][0], 1'b0} + {2'b0, p[2][0]};
    yb  = {2'b0, p[2][0]} + {1'b0, p[2][1], 1'b0} + {2'b0, p[2][2]};
    yt  = {2'b0, p[0][0]} + {1'b0, p[0][1], 1'b0} + {2'b0, p[0][2]};
    gx  = $signed({2'b0, xr}) - $signed({2'b0, xl});
    gy  = $signed({2'b0, yb}) - $signed({2'b0, yt});
    ax  = gx[11] ? -gx : gx;
    ay  = gy[11] ? -gy : gy;
    mag = ax + ay;
  end
  always_ff @(posedge clk)
    if (rst) begin
      edge_mag   <= '0;
      edge_valid <= 1'b0;
    end else begin
      edge_valid <= v1;
      if (v1)
        edge_mag <= bord ? '0 : (|mag[11:8] ? 8'hff : mag[7:0]);
    end
endmodule
